// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// fifo_pkg
//   Shared types, constants and the data-field rule for the FIFO read side.
//   Revision: 1.0
// ============================================================================
package fifo_pkg;

    localparam int         DATA_W    = 32;
    localparam int         PTR_W     = 5;
    localparam logic [7:0] LO_THRESH = 8'd150;
    localparam logic [7:0] HI_LIMIT  = 8'd230;

    typedef logic [DATA_W-1:0] fifo_word_t;
    typedef logic [PTR_W-1:0]  fifo_ptr_t;

    // A word is legal unless byte0 arms the rule and byte3 exceeds the limit.
    function automatic logic field_rule_ok(input fifo_word_t word,
                                           input logic [7:0] lo = LO_THRESH,
                                           input logic [7:0] hi = HI_LIMIT);
        return !((word[7:0] > lo) && (word[31:24] > hi));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_skid_buf.sv
`default_nettype none
// ============================================================================
// fifo_skid_buf
//   Small circular buffer with write/read strobes, occupancy and head data.
//   Revision: 1.0
// ============================================================================
module fifo_skid_buf #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 32,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [OW-1:0]    occ,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;

    // Explicit wrap so non-power-of-two depths stay modulo DEPTH.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (rd_en) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_drain_ctrl
//   Pops the sync FIFO, absorbs its read latency in a skid buffer, streams the
//   words out on valid/ready and flags byte0/byte3 field-rule violations.
//   Optional pop/violation counters: define FIFO_DRAIN_STATS_EN.
//   Revision: 1.0
// ============================================================================
module fifo_drain_ctrl #(
    parameter int         DATA_W    = fifo_pkg::DATA_W,
    parameter int         BUF_DEPTH = 2,
    parameter logic [7:0] LO_THRESH = fifo_pkg::LO_THRESH,
    parameter logic [7:0] HI_LIMIT  = fifo_pkg::HI_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              rd_enable,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              rule_err,
    output logic [15:0]       pop_count,
    output logic [7:0]        err_count
);
    import fifo_pkg::*;

    localparam int OW = $clog2(BUF_DEPTH + 1);

    logic              inflight_q, inflight_d;
    logic              rule_err_q, rule_err_d;
    logic [OW-1:0]     occ;
    logic [DATA_W-1:0] head;
    logic              pop;
    logic              viol;
    logic              issue;

    fifo_skid_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (inflight_q),
        .wr_data   (fifo_rdata),
        .rd_en     (pop),
        .occ       (occ),
        .head_data (head)
    );

    // Only pop when the word returning next cycle is guaranteed a slot.
    always_comb begin
        pop        = m_valid && m_ready;
        issue      = !reset && !empty &&
                     ((int'(occ) + int'(inflight_q) - int'(pop)) < BUF_DEPTH);
        inflight_d = issue;
        viol       = inflight_q && !field_rule_ok(fifo_word_t'(fifo_rdata), LO_THRESH, HI_LIMIT);
        rule_err_d = rule_err_q || viol;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 1'b0;
            rule_err_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            rule_err_q <= rule_err_d;
        end
    end

    assign rd_enable = issue;
    assign m_valid   = !reset && (occ != '0);
    assign m_data    = reset ? '0 : head;
    assign rule_err  = !reset && rule_err_q;

`ifdef FIFO_DRAIN_STATS_EN
    logic [15:0] pop_count_q, pop_count_d;
    logic [7:0]  err_count_q, err_count_d;

    always_comb begin
        pop_count_d = pop_count_q;
        err_count_d = err_count_q;
        if (issue && (pop_count_q != 16'hFFFF)) begin
            pop_count_d = pop_count_q + 16'd1;
        end
        if (viol && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pop_count_q <= '0;
            err_count_q <= '0;
        end else begin
            pop_count_q <= pop_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign pop_count = reset ? '0 : pop_count_q;
    assign err_count = reset ? '0 : err_count_q;
`else
    assign pop_count = '0;
    assign err_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fifo_drain_ctrl
//   Scoreboard bench: upstream FIFO modelled as a queue with 1-cycle read
//   latency; a monitor checks every delivered beat against the expected order.
//   Revision: 1.0
// ============================================================================
module tb_fifo_drain_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        empty;
    logic [31:0] fifo_rdata;
    logic        rd_enable;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        rule_err;
    logic [15:0] pop_count;
    logic [7:0]  err_count;

    fifo_drain_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .empty      (empty),
        .fifo_rdata (fifo_rdata),
        .rd_enable  (rd_enable),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .rule_err   (rule_err),
        .pop_count  (pop_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] fifo_q [$];
    logic [31:0] exp_q  [$];
    int          dq     [$];
    int          cyc        = 0;
    int          deliv_n    = 0;
    int          deliv_viol = 0;
    int          ready_mode = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit violates(input logic [31:0] w);
        int unsigned v;
        int unsigned b0;
        int unsigned b3;
        v  = w;
        b0 = v % 256;
        b3 = v / 16777216;
        return (b0 > 150) && (b3 > 230);
    endfunction

    // Monitor: every accepted beat must be the oldest outstanding word.
    always @(negedge clk) begin
        logic [31:0] e;
        cyc++;
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk_eq("hold_valid", m_valid, 1);
                chk_eq("hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk_eq("beat_with_nothing_outstanding", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk_eq("m_data", m_data, e);
                    deliv_n++;
                    dq.push_back(cyc);
                    if (violates(e)) begin
                        deliv_viol++;
                        chk_eq("rule_err_on_bad_word", rule_err, 1);
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // One clock: sample the pop request, then return data with 1-cycle latency.
    task automatic tick();
        bit r;
        @(negedge clk);
        r = rd_enable;
        if (r) chk_eq("rd_enable_while_empty", empty, 0);
        @(posedge clk);
        #1;
        if (r && fifo_q.size() != 0) fifo_rdata = fifo_q.pop_front();
        else                         fifo_rdata = $urandom;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        empty = (fifo_q.size() == 0);
    endtask

    task automatic load(input logic [31:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        empty = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        ready_mode = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && k < 300) begin
            tick();
            k++;
        end
        chk_eq("drain_outstanding", fifo_q.size() + exp_q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic quiesce_check(input string tag);
        chk_eq({tag, "_m_valid_idle"}, m_valid, 0);
        chk_eq({tag, "_rule_err"}, rule_err, (deliv_viol > 0));
`ifdef FIFO_DRAIN_STATS_EN
        chk_eq({tag, "_pop_count"}, pop_count, deliv_n);
        chk_eq({tag, "_err_count"}, err_count, deliv_viol);
`else
        chk_eq({tag, "_pop_count"}, pop_count, 0);
        chk_eq({tag, "_err_count"}, err_count, 0);
`endif
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: begin w[7:0] = 8'($urandom_range(145, 160)); w[31:24] = 8'($urandom_range(225, 240)); end
            1: begin w[7:0] = 8'($urandom_range(151, 255)); w[31:24] = 8'($urandom_range(231, 255)); end
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        reset      = 1'b1;
        empty      = 1'b1;
        m_ready    = 1'b0;
        fifo_rdata = '0;

        // Reset cycle outputs
        @(negedge clk);
        chk_eq("rst_rd_enable", rd_enable, 0);
        chk_eq("rst_m_valid", m_valid, 0);
        chk_eq("rst_m_data", m_data, 0);
        chk_eq("rst_rule_err", rule_err, 0);
        chk_eq("rst_pop_count", pop_count, 0);
        chk_eq("rst_err_count", err_count, 0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_ready = 1'b1;

        // Latency of a single word
        load(32'h11111101);
        #1;
        chk_eq("lat_rd_enable_t", rd_enable, 1);
        chk_eq("lat_m_valid_t", m_valid, 0);
        tick();
        #1;
        chk_eq("lat_rd_enable_t1", rd_enable, 0);
        chk_eq("lat_m_valid_t1", m_valid, 0);
        tick();
        #1;
        chk_eq("lat_m_valid_t2", m_valid, 1);
        chk_eq("lat_m_data_t2", m_data, 32'h11111101);
        drain();
        quiesce_check("single");

        // Boundary word: byte3 exactly at limit is legal
        load(32'hE6000097);
        drain();
        quiesce_check("at_limit");
        chk_eq("at_limit_rule_err_low", rule_err, 0);

        // Violating word is flagged and still delivered
        load(32'hE7000097);
        drain();
        quiesce_check("violation");
        chk_eq("violation_rule_err", rule_err, 1);
`ifdef FIFO_DRAIN_STATS_EN
        chk_eq("stats_pop_count_3", pop_count, 3);
        chk_eq("stats_err_count_1", err_count, 1);
`else
        chk_eq("nostats_pop_count", pop_count, 0);
        chk_eq("nostats_err_count", err_count, 0);
`endif

        // Reset while a word is in flight: it is lost, nothing captured
        load(32'hE7000097);
        #1;
        chk_eq("rstmid_rd_enable", rd_enable, 1);
        tick();
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk_eq("rstmid_m_valid_in_reset", m_valid, 0);
        tick();
        reset      = 1'b0;
        deliv_n    = 0;
        deliv_viol = 0;
        #1;
        chk_eq("rstmid_m_valid_after", m_valid, 0);
        chk_eq("rstmid_rule_err_after", rule_err, 0);
        tick();
        #1;
        chk_eq("rstmid_no_capture_valid", m_valid, 0);
        chk_eq("rstmid_no_capture_err", rule_err, 0);
        quiesce_check("rstmid");

        // Full throughput: 8 beats back to back
        ready_mode = 0;
        m_ready    = 1'b1;
        dq.delete();
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            w[31:24] = 8'(i);
            load(w);
        end
        drain();
        chk_eq("thru_beats", dq.size(), 8);
        if (dq.size() == 8) chk_eq("thru_no_gaps", dq[7] - dq[0], 7);
        quiesce_check("thru");

        // Backpressure: buffer fills to two words and pops stop
        ready_mode = 1;
        m_ready    = 1'b0;
        for (int i = 0; i < 8; i++) load(32'hA5000000 | 32'(i));
        repeat (10) tick();
        #1;
        chk_eq("bp_rd_enable", rd_enable, 0);
        chk_eq("bp_m_valid", m_valid, 1);
        chk_eq("bp_words_popped", 8 - fifo_q.size(), 2);
        chk_eq("bp_head", m_data, exp_q[0]);
        drain();
        quiesce_check("bp");

        // Randomised traffic and backpressure
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 32) load(rand_word());
            tick();
        end
        drain();
        quiesce_check("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
